// File: rtl/uart_pkg.sv
// Shared register map, bit positions and defaults for the UART receive controller.
// Consumed by uart_rx_ctrl and uart_rx_fifo.
package uart_pkg;

    localparam logic [3:0] ADDR_DATA   = 4'h0;
    localparam logic [3:0] ADDR_STATUS = 4'h4;
    localparam logic [3:0] ADDR_CTRL   = 4'h8;
    localparam logic [3:0] ADDR_CLEAR  = 4'hC;

    localparam int CTRL_ENABLE_BIT = 0;
    localparam int CTRL_IRQ_EN_BIT = 1;
    localparam int CTRL_THR_LSB    = 4;

    localparam int STAT_NOT_EMPTY_BIT = 0;
    localparam int STAT_FULL_BIT      = 1;
    localparam int STAT_OVERRUN_BIT   = 2;
    localparam int STAT_TIMEOUT_BIT   = 3;
    localparam int STAT_COUNT_LSB     = 8;

    localparam int CLR_OVERRUN_BIT = 2;
    localparam int CLR_TIMEOUT_BIT = 3;
    localparam int CLR_FLUSH_BIT   = 4;

    // Four characters of idle line at 16x oversampling.
    localparam int TIMEOUT_CYCLES_DEFAULT = 640;

    typedef struct packed {
        logic [3:0] threshold;
        logic       irq_en;
        logic       enable;
    } ctrl_t;

    // A programmed threshold of 0 behaves as 1.
    function automatic logic [3:0] eff_threshold(input logic [3:0] thr);
        return (thr == 4'd0) ? 4'd1 : thr;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO: power-of-two depth, wrapping pointers, count 0..DEPTH.
// Storage is not reset; only pointers and count are.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [7:0]               din,
    output logic [7:0]               dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full  = (count_q == DEPTH_CNT);
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    // A push into a full FIFO only lands when a pop frees a slot in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: CTRL/STATUS/CLEAR/DATA registers, FIFO and level irq.
// Optional idle-timeout feature built when UART_RX_TIMEOUT_EN is defined.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_done,
    input  logic [7:0]  rx_data,
    input  logic [3:0]  bus_addr,
    input  logic        bus_rd,
    input  logic        bus_wr,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    output logic        irq
);
    // Bus: bus_rd/bus_wr are single-cycle strobes, never both high; read data is
    // presented on bus_rdata the cycle after bus_rd and is 0 in every other cycle.
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    ctrl_t       ctrl_q, ctrl_d;
    logic        overrun_q, overrun_d;
    logic [31:0] rdata_q, rdata_d;
    logic        irq_q, irq_d;
    logic        timeout_flag;

    logic          fifo_full, fifo_empty;
    logic [7:0]    fifo_dout;
    logic [CW-1:0] fifo_count;
    logic          push, pop, flush, rd_data, wr_ctrl, wr_clear;
    logic [31:0]   status_word, ctrl_word;
    logic          unused_wdata;

    assign rd_data  = bus_rd && (bus_addr == ADDR_DATA);
    assign wr_ctrl  = bus_wr && (bus_addr == ADDR_CTRL);
    assign wr_clear = bus_wr && (bus_addr == ADDR_CLEAR);
    assign push     = rx_done && ctrl_q.enable;
    assign pop      = rd_data && !fifo_empty;
    assign flush    = wr_clear && bus_wdata[CLR_FLUSH_BIT];

    assign unused_wdata = ^{bus_wdata[31:8], bus_wdata[3]};

    uart_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   (rx_data),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

`ifdef UART_RX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES);

    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          timeout_q, timeout_d, tmo_set;

    // Counts idle cycles with data waiting; saturates so timeout fires once.
    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        tmo_set   = 1'b0;
        if (push || pop || fifo_empty) begin
            tmo_cnt_d = '0;
        end else if (tmo_cnt_q != TMO_MAX) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
            tmo_set   = (tmo_cnt_d == TMO_MAX);
        end
        timeout_d = (timeout_q && !(wr_clear && bus_wdata[CLR_TIMEOUT_BIT])) || tmo_set;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_flag = timeout_q;
`else
    assign timeout_flag = 1'b0;
`endif

    always_comb begin
        status_word = '0;
        status_word[STAT_NOT_EMPTY_BIT]  = !fifo_empty;
        status_word[STAT_FULL_BIT]       = fifo_full;
        status_word[STAT_OVERRUN_BIT]    = overrun_q;
        status_word[STAT_TIMEOUT_BIT]    = timeout_flag;
        status_word[STAT_COUNT_LSB +: 5] = 5'(fifo_count);

        ctrl_word = '0;
        ctrl_word[CTRL_ENABLE_BIT]      = ctrl_q.enable;
        ctrl_word[CTRL_IRQ_EN_BIT]      = ctrl_q.irq_en;
        ctrl_word[CTRL_THR_LSB +: 4]    = ctrl_q.threshold;
    end

    always_comb begin
        ctrl_d = ctrl_q;
        if (wr_ctrl) begin
            ctrl_d.enable    = bus_wdata[CTRL_ENABLE_BIT];
            ctrl_d.irq_en    = bus_wdata[CTRL_IRQ_EN_BIT];
            ctrl_d.threshold = bus_wdata[CTRL_THR_LSB +: 4];
        end

        // Set beats a simultaneous write-1-to-clear.
        overrun_d = (overrun_q && !(wr_clear && bus_wdata[CLR_OVERRUN_BIT]))
                    || (push && fifo_full && !pop);

        rdata_d = '0;
        if (bus_rd) begin
            case (bus_addr)
                ADDR_DATA:   rdata_d = fifo_empty ? 32'd0 : {24'd0, fifo_dout};
                ADDR_STATUS: rdata_d = status_word;
                ADDR_CTRL:   rdata_d = ctrl_word;
                default:     rdata_d = '0;
            endcase
        end

        irq_d = ctrl_q.irq_en &&
                (({1'b0, eff_threshold(ctrl_q.threshold)} <= 5'(fifo_count))
                 || overrun_q || timeout_flag);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q    <= '0;
            overrun_q <= 1'b0;
            rdata_q   <= '0;
            irq_q     <= 1'b0;
        end else begin
            ctrl_q    <= ctrl_d;
            overrun_q <= overrun_d;
            rdata_q   <= rdata_d;
            irq_q     <= irq_d;
        end
    end

    assign bus_rdata = rdata_q;
    assign irq       = irq_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: directed scenarios plus random traffic,
// bus reads checked by a scoreboard against a queue-based reference model.
module tb_uart_rx_ctrl;

    localparam int DEPTH = 8;
    localparam int TMO   = 640;
`ifdef UART_RX_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        rx_done;
    logic [7:0]  rx_data;
    logic [3:0]  bus_addr;
    logic        bus_rd;
    logic        bus_wr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        irq;

    uart_rx_ctrl #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_done   (rx_done),
        .rx_data   (rx_data),
        .bus_addr  (bus_addr),
        .bus_rd    (bus_rd),
        .bus_wr    (bus_wr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .irq       (irq)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];
    string       name_q[$];
    logic        rd_seen;

    // ---------------- reference model ----------------
    logic [7:0]  m_fifo[$];
    logic [31:0] m_ctrl;
    bit          m_ovr;
    bit          m_tmo;
    int          m_idle;

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        s = 32'(m_fifo.size()) << 8;
        s[0] = (m_fifo.size() > 0);
        s[1] = (m_fifo.size() == DEPTH);
        s[2] = m_ovr;
        s[3] = m_tmo;
        return s;
    endfunction

    function automatic bit m_irq();
        int thr;
        thr = int'(m_ctrl[7:4]);
        if (thr == 0) thr = 1;
        return m_ctrl[1] && ((m_fifo.size() >= thr) || m_ovr || m_tmo);
    endfunction

    // Idle accounting on the state before the edge; returns 1 when timeout fires.
    function automatic bit m_tick(input bit moved);
        if (moved || m_fifo.size() == 0) begin
            m_idle = 0;
            return 1'b0;
        end
        if (m_idle < TMO) begin
            m_idle++;
            return TMO_EN && (m_idle == TMO);
        end
        return 1'b0;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    always @(posedge clk) rd_seen <= bus_rd;

    always @(negedge clk) begin
        if (rd_seen === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_read", bus_rdata, 32'hDEAD_BEEF);
            end else begin
                check(name_q.pop_front(), bus_rdata, exp_q.pop_front());
            end
        end
    end

    // ---------------- driver ----------------
    // One clock of stimulus, entered and left at a negedge; updates the model
    // and checks irq against the model state before this edge.
    task automatic cycle(input bit rx, input logic [7:0] b, input bit rd, input bit wr,
                         input logic [3:0] addr, input logic [31:0] wd, input string nm);
        int          pre_size;
        bit          do_pop, do_push, ovr_set, tmo_set;
        logic [31:0] exp;
        bit          exp_irq;
        exp_irq  = m_irq();
        pre_size = m_fifo.size();
        do_pop   = rd && (addr == 4'h0) && (pre_size > 0);
        do_push  = rx && m_ctrl[0];
        case (addr)
            4'h0:    exp = (pre_size > 0) ? {24'd0, m_fifo[0]} : 32'd0;
            4'h4:    exp = m_status();
            4'h8:    exp = m_ctrl;
            default: exp = 32'd0;
        endcase
        tmo_set = m_tick(do_push || do_pop);
        if (rd) begin
            exp_q.push_back(exp);
            name_q.push_back(nm);
        end
        ovr_set = do_push && (pre_size == DEPTH) && !do_pop;
        if (do_pop) void'(m_fifo.pop_front());
        if (do_push && !ovr_set) m_fifo.push_back(b);
        if (wr && addr == 4'hC) begin
            if (wd[2]) m_ovr = 1'b0;
            if (wd[3]) m_tmo = 1'b0;
            if (wd[4]) m_fifo.delete();
        end
        if (wr && addr == 4'h8) m_ctrl = wd & 32'h0000_00F3;
        m_ovr = m_ovr || ovr_set;
        m_tmo = m_tmo || tmo_set;

        rx_done = rx; rx_data = b; bus_rd = rd; bus_wr = wr; bus_addr = addr; bus_wdata = wd;
        @(negedge clk);
        rx_done = 1'b0; bus_rd = 1'b0; bus_wr = 1'b0;
        check({nm, "_irq"}, {31'd0, irq}, {31'd0, exp_irq});
    endtask

    task automatic rx_byte(input logic [7:0] b);
        cycle(1'b1, b, 1'b0, 1'b0, 4'h0, 32'd0, "rx");
    endtask

    task automatic rd_reg(input logic [3:0] a, input string nm);
        cycle(1'b0, 8'd0, 1'b1, 1'b0, a, 32'd0, nm);
    endtask

    task automatic wr_reg(input logic [3:0] a, input logic [31:0] d);
        cycle(1'b0, 8'd0, 1'b0, 1'b1, a, d, "wr");
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'd0, 1'b0, 1'b0, 4'h0, 32'd0, "idle");
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_fifo.delete();
        m_ctrl = 32'd0;
        m_ovr  = 1'b0;
        m_tmo  = 1'b0;
        m_idle = 0;
        check("reset_rdata", bus_rdata, 32'd0);
        check("reset_irq", {31'd0, irq}, 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int r;
        rst = 1'b1; rx_done = 1'b0; rx_data = 8'd0; bus_addr = 4'h0;
        bus_rd = 1'b0; bus_wr = 1'b0; bus_wdata = 32'd0;
        m_ctrl = 32'd0; m_ovr = 1'b0; m_tmo = 1'b0; m_idle = 0;
        @(negedge clk);
        do_reset();

        // single byte round trip
        rd_reg(4'h4, "status_after_reset");
        wr_reg(4'h8, 32'h11);
        rx_byte(8'hA5);
        rd_reg(4'h4, "status_one_byte");
        rd_reg(4'h0, "data_a5");
        rd_reg(4'h4, "status_drained");
        rd_reg(4'h0, "data_empty");

        // fill, overflow by one, drain
        do_reset();
        wr_reg(4'h8, 32'h01);
        for (int i = 0; i < DEPTH; i++) rx_byte(8'(i));
        rx_byte(8'hFF);
        rd_reg(4'h4, "status_overrun");
        for (int i = 0; i < DEPTH; i++) rd_reg(4'h0, "data_fill");
        rd_reg(4'h0, "data_after_fill");

        // push and pop together while full
        do_reset();
        wr_reg(4'h8, 32'h01);
        for (int i = 0; i < DEPTH; i++) rx_byte(8'h10 + 8'(i));
        cycle(1'b1, 8'h5A, 1'b1, 1'b0, 4'h0, 32'd0, "data_push_pop_full");
        rd_reg(4'h4, "status_push_pop_full");
        for (int i = 0; i < DEPTH; i++) rd_reg(4'h0, "data_push_pop_drain");

        // set wins over simultaneous clear
        for (int i = 0; i < DEPTH; i++) rx_byte(8'h20 + 8'(i));
        cycle(1'b1, 8'h77, 1'b0, 1'b1, 4'hC, 32'h4, "rx_and_clear");
        rd_reg(4'h4, "status_set_wins");
        wr_reg(4'hC, 32'h4);
        rd_reg(4'h4, "status_ovr_cleared");
        wr_reg(4'h8, 32'h00);
        rd_reg(4'h0, "data_after_disable");
        wr_reg(4'hC, 32'h10);
        rd_reg(4'h4, "status_flushed");

        // threshold irq
        do_reset();
        wr_reg(4'h8, 32'h33);
        rx_byte(8'h01);
        rx_byte(8'h02);
        idle(1);
        rx_byte(8'h03);
        idle(2);
        rd_reg(4'h0, "data_thr");
        idle(2);

        // idle timeout
        do_reset();
        wr_reg(4'h8, 32'hF3);
        rx_byte(8'h42);
        idle(TMO - 3);
        rd_reg(4'h4, "status_pre_timeout");
        idle(4);
        rd_reg(4'h4, "status_timeout");
        wr_reg(4'hC, 32'h8);
        rd_reg(4'h4, "status_timeout_cleared");

        // reset mid-traffic
        do_reset();
        wr_reg(4'h8, 32'h01);
        for (int i = 0; i < DEPTH + 1; i++) rx_byte(8'($urandom_range(0, 255)));
        do_reset();
        rd_reg(4'h4, "status_after_midreset");
        rd_reg(4'h8, "ctrl_after_midreset");
        rx_byte(8'h99);
        rd_reg(4'h4, "status_disabled_rx");
        rd_reg(4'h0, "data_disabled_rx");

        // random traffic
        wr_reg(4'h8, 32'h31);
        for (int n = 0; n < 600; n++) begin
            r = $urandom_range(0, 99);
            if (r < 38)      rx_byte(8'($urandom_range(0, 255)));
            else if (r < 58) rd_reg(4'h0, "rand_data");
            else if (r < 68) rd_reg(4'h4, "rand_status");
            else if (r < 74) cycle(1'b1, 8'($urandom_range(0, 255)), 1'b1, 1'b0, 4'h0, 32'd0, "rand_push_pop");
            else if (r < 79) wr_reg(4'h8, {$urandom_range(0, 255)} | ($urandom_range(0, 3) != 0 ? 32'h1 : 32'h0));
            else if (r < 84) wr_reg(4'hC, 32'($urandom_range(0, 3)) << 2 | ($urandom_range(0, 5) == 0 ? 32'h10 : 32'h0));
            else if (r < 88) rd_reg(4'h8, "rand_ctrl");
            else if (r < 92) rd_reg(4'($urandom_range(0, 15)) | 4'h1, "rand_undef_rd");
            else if (r < 95) wr_reg(4'($urandom_range(0, 15)) | 4'h2, $urandom);
            else if (r < 97) cycle(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b1, 4'hC, 32'h4, "rand_rx_clear");
            else             idle($urandom_range(1, 20));
        end

        idle(3);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
